banco_reg_escrita: RTL and testbench

Write side of the register bank: the counterpart of the read-path multiplexers. It accepts write requests over a valid/ready handshake and decodes the 5-bit address to a one-hot register enable. It updates a DEPTH x WIDTH register array and exports the full array contents to the read muxes. It also runs a multi-cycle bulk-clear sequence driven by an internal FSM and counter, and counts committed writes.

---
 rtl/banco_reg_escrita.sv | 126 ++++++++++++
 tb/tb_banco_reg_escrita.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_escrita.sv
// banco_reg_escrita: write side of the register bank.
//
// Accepts writes over a valid/ready handshake, decodes the address to a
// one-hot enable and updates a DEPTH x WIDTH register array that is exported
// flat to the read muxes. A one-cycle clear_req starts a DEPTH-cycle bulk clear
// that zeroes one register per cycle. Committed writes are counted mod 2^16.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   wr_valid_i   write request valid
//   wr_ready_o   write can be accepted this cycle (IDLE and no clear_req)
//   wr_addr_i    target register index
//   wr_data_i    write data
//   clear_req_i  request to zero every register
//   busy_o       clear sequence in progress
//   wr_onehot_o  one-hot enable of the last committed write, one cycle wide
//   q_o          flattened register contents, reg i at [i*WIDTH +: WIDTH]
//   wr_count_o   committed write count, wraps modulo 2^16
module banco_reg_escrita #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   clear_req_i,
    output logic                   busy_o,
    output logic [DEPTH-1:0]       wr_onehot_o,
    output logic [DEPTH*WIDTH-1:0] q_o,
    output logic [15:0]            wr_count_o
);

    typedef enum logic {StIdle, StClear} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_e                        state_q, state_d;
    logic   [ADDR_W-1:0]           cnt_q, cnt_d;
    logic   [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic   [DEPTH-1:0]            onehot_q, onehot_d;
    logic   [15:0]                 count_q, count_d;
    logic   [DEPTH-1:0]            dec;
    logic                          commit;

    assign wr_ready_o  = (state_q == StIdle) && !clear_req_i;
    assign commit      = wr_valid_i && wr_ready_o;
    assign busy_o      = (state_q == StClear);
    assign wr_onehot_o = onehot_q;
    assign q_o         = regs_q;
    assign wr_count_o  = count_q;

    // Address decoder gated by the commit; a hardwired-zero register 0 never
    // gets an enable, so it keeps its reset value of 0 forever.
    always_comb begin
        dec = '0;
        if (commit) begin
            dec[wr_addr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            dec[0] = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        onehot_d = dec;
        count_d  = count_q;

        if (commit) begin
            count_d = count_q + 16'd1;
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (dec[i]) begin
                regs_d[i] = wr_data_i;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (clear_req_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // commit is impossible here (wr_ready_o is low), so no conflict
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            regs_q   <= '0;
            onehot_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            regs_q   <= regs_d;
            onehot_q <= onehot_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_banco_reg_escrita.sv
module tb_banco_reg_escrita;

    localparam int W = 32;
    localparam int D = 32;

    logic             clk;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [W-1:0]     wr_data;
    logic             clear_req;
    logic             busy;
    logic [D-1:0]     wr_onehot;
    logic [D*W-1:0]   q;
    logic [15:0]      wr_count;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model [D];

    banco_reg_escrita #(
        .WIDTH   (W),
        .DEPTH   (D),
        .ADDR_W  (5),
        .ZERO_REG(1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clear_req_i(clear_req),
        .busy_o     (busy),
        .wr_onehot_o(wr_onehot),
        .q_o        (q),
        .wr_count_o (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_onehot;
        logic [15:0] exp_count;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return q[i*W +: W];
    endfunction

    task automatic check_all(input string name);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("%s_r%0d", name, i), reg_of(i), model[i]);
        end
    endtask

    initial begin
        int busy_cycles;
        int not_ready;

        vecs[0] = '{5'd5,  32'hDEADBEEF, 32'h0000_0020, 16'd1, 32'hDEADBEEF};
        vecs[1] = '{5'd0,  32'hFFFFFFFF, 32'h0000_0000, 16'd2, 32'h0000_0000};
        vecs[2] = '{5'd31, 32'h0000_0001, 32'h8000_0000, 16'd3, 32'h0000_0001};
        vecs[3] = '{5'd31, 32'h0000_0002, 32'h8000_0000, 16'd4, 32'h0000_0002};
        vecs[4] = '{5'd1,  32'h12345678, 32'h0000_0002, 16'd5, 32'h12345678};
        vecs[5] = '{5'd17, 32'hA5A5A5A5, 32'h0002_0000, 16'd6, 32'hA5A5A5A5};

        for (int i = 0; i < D; i++) model[i] = '0;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;

        // Reset values, before any clock edge
        #1;
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        chk("rst_onehot", wr_onehot, 32'd0);
        check_all("rst_q");

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table writes, one per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_addr  = vecs[i].addr;
            wr_data  = vecs[i].data;
            chk($sformatf("v%0d_ready", i), 32'(wr_ready), 32'd1);
            @(posedge clk);
            #1;
            if (vecs[i].addr != 5'd0) model[vecs[i].addr] = vecs[i].data;
            chk($sformatf("v%0d_onehot", i), wr_onehot, vecs[i].exp_onehot);
            chk($sformatf("v%0d_count", i), 32'(wr_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_reg", i), reg_of(int'(vecs[i].addr)), vecs[i].exp_reg);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_onehot", wr_onehot, 32'd0);
        chk("idle_count", 32'(wr_count), 32'd6);
        check_all("table_q");

        // Fill every register with its index
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = 32'(i);
            @(posedge clk);
            #1;
            if (i != 0) model[i] = 32'(i);
        end
        chk("fill_count", 32'(wr_count), 32'd38);
        check_all("fill_q");

        // Clear collides with a write; the write is held through the clear,
        // and a second clear_req mid-sequence must not extend it.
        @(negedge clk);
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'h77;
        #1;
        chk("coll_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        busy_cycles = busy ? 1 : 0;
        not_ready   = wr_ready ? 0 : 1;
        chk("clr_enter_count", 32'(wr_count), 32'd38);
        for (int k = 1; k <= D; k++) begin
            @(negedge clk);
            clear_req = (k == 10);
            @(posedge clk);
            #1;
            model[k-1] = '0;
            if (busy) busy_cycles++;
            if (!wr_ready) not_ready++;
            if (k == 8) check_all("clr_k8");
            if (k == 20) check_all("clr_k20");
        end
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd32);
        chk("clr_notready_cycles", 32'(not_ready), 32'd32);
        chk("clr_end_busy", 32'(busy), 32'd0);
        chk("clr_end_count", 32'(wr_count), 32'd38);
        check_all("clr_end_q");
        @(posedge clk);
        #1;
        model[7] = 32'h77;
        chk("held_onehot", wr_onehot, 32'h0000_0080);
        chk("held_count", 32'(wr_count), 32'd39);
        check_all("held_q");

        // Load two registers, start a clear, reset at clear cycle 10
        @(negedge clk);
        wr_addr = 5'd20;
        wr_data = 32'h20202020;
        @(negedge clk);
        wr_addr = 5'd30;
        wr_data = 32'h30;
        @(negedge clk);
        wr_valid  = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_count", 32'(wr_count), 32'd41);
        chk("mid_r20", reg_of(20), 32'h20202020);
        chk("mid_r9", reg_of(9), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < D; i++) model[i] = '0;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        chk("arst_count", 32'(wr_count), 32'd0);
        check_all("arst_q");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // 65536 commits wrap the counter back to 0
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = '0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            wr_data = 32'(i);
            @(posedge clk);
            #1;
            if (i == 65534) chk("wrap_ffff", 32'(wr_count), 32'h0000_FFFF);
        end
        chk("wrap_zero", 32'(wr_count), 32'd0);
        chk("wrap_r3", reg_of(3), 32'h0000_FFFF);
        @(negedge clk);
        wr_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
